// File: rtl/vwb_pkg.sv
// Shared sizing helpers and the saturating clip used by the streaming affine unit.
package vwb_pkg;

    localparam int ClipW = 64;

    typedef struct packed {
        logic [ClipW-1:0] val;
        logic             flag;
    } clip_t;

    function automatic int nbits(input int int_bits, input int frac_bits);
        return int_bits + frac_bits;
    endfunction

    function automatic int num_chunks(input int vec_len, input int regs);
        return vec_len / regs;
    endfunction

    function automatic int ptr_width(input int n_chunks);
        return (n_chunks > 1) ? $clog2(n_chunks) : 1;
    endfunction

    // Clamp a wide signed value into an nb-bit signed range; flag set when clipped.
    function automatic clip_t sat_clip(input logic signed [ClipW-1:0] value, input int nb);
        logic signed [ClipW-1:0] hi;
        logic signed [ClipW-1:0] lo;
        clip_t                   res;
        hi       = $signed((ClipW'(1) << (nb - 1)) - ClipW'(1));
        lo       = ~hi;
        res.val  = value;
        res.flag = 1'b0;
        if (value > hi) begin
            res.val  = hi;
            res.flag = 1'b1;
        end else if (value < lo) begin
            res.val  = lo;
            res.flag = 1'b1;
        end
        return res;
    endfunction

endpackage

// File: rtl/vwb_lane.sv
// One lane of the affine datapath: S1 multiply, S2 round/bias/clip/ReLU.
module vwb_lane
    import vwb_pkg::*;
#(
    parameter int NBits    = 16,
    parameter int FracBits = 12,
    parameter int Saturate = 1
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             en,
    input  logic             relu,
    input  logic [NBits-1:0] x,
    input  logic [NBits-1:0] w,
    input  logic [NBits-1:0] b,
    output logic [NBits-1:0] y,
    output logic             sat
);

    localparam int PW = 2 * NBits;
    localparam logic signed [PW-1:0] Half = PW'(1) <<< (FracBits - 1);

    logic signed [PW-1:0] p_q, p_d;
    logic signed [PW-1:0] r, s;
    logic [NBits-1:0]     b_q, b_d;
    logic [NBits-1:0]     y_q, y_d;
    logic                 relu_q, relu_d;
    logic                 sat_q, sat_d;
    clip_t                clip;
    logic                 unused_clip_hi;

    always_comb begin
        p_d            = p_q;
        b_d            = b_q;
        relu_d         = relu_q;
        y_d            = y_q;
        sat_d          = sat_q;
        r              = (p_q + Half) >>> FracBits;
        s              = r + PW'($signed(b_q));
        clip           = sat_clip(ClipW'(s), NBits);
        unused_clip_hi = ^clip.val[ClipW-1:NBits];
        if (en) begin
            p_d    = PW'($signed(x)) * PW'($signed(w));
            b_d    = b;
            relu_d = relu;
            if (Saturate != 0) begin
                y_d   = clip.val[NBits-1:0];
                sat_d = clip.flag;
            end else begin
                y_d   = s[NBits-1:0];
                sat_d = 1'b0;
            end
            // ReLU acts on the already clamped (or wrapped) result.
            if (relu_q && y_d[NBits-1]) begin
                y_d = '0;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            p_q    <= '0;
            b_q    <= '0;
            relu_q <= 1'b0;
            y_q    <= '0;
            sat_q  <= 1'b0;
        end else begin
            p_q    <= p_d;
            b_q    <= b_d;
            relu_q <= relu_d;
            y_q    <= y_d;
            sat_q  <= sat_d;
        end
    end

    assign y   = y_q;
    assign sat = sat_q;

endmodule

// File: rtl/vwb_sp_ram.sv
// Single-port synchronous RAM wrapper; used read-only as a coefficient ROM.
module vwb_sp_ram #(
    parameter int                       Width    = 64,
    parameter int                       Depth    = 4,
    parameter int                       AddrW    = 2,
    parameter string                    InitFile = "",
    parameter logic [Width*Depth-1:0]   InitData = '0
) (
    input  logic             clk_in,
    input  logic             ena,
    input  logic             wea,
    input  logic [AddrW-1:0] addr,
    input  logic [Width-1:0] din,
    output logic [Width-1:0] dout
);

    logic [Width-1:0] mem [Depth];
    logic [Width-1:0] dout_q;

    initial begin
        for (int i = 0; i < Depth; i++) begin
            mem[i] = InitData[i*Width +: Width];
        end
    end

    always_ff @(posedge clk_in) begin
        if (ena) begin
            if (wea) begin
                mem[addr] <= din;
            end
            dout_q <= mem[addr];
        end
    end

    assign dout = dout_q;

endmodule

// File: rtl/vwb_mac_stream.sv
// Streaming element-wise affine unit y = sat(round(w*x) + b) with optional ReLU.
// Three-stage pipeline frozen as a whole while the output is back-pressured.
module vwb_mac_stream
    import vwb_pkg::*;
#(
    parameter int    InVecLength = 16,
    parameter int    WorkingRegs = 4,
    parameter int    IntBits     = 4,
    parameter int    FracBits    = 12,
    parameter int    Saturate    = 1,
    parameter string WeightFile  = "",
    parameter string BiasFile    = "",
    parameter logic [InVecLength*(IntBits+FracBits)-1:0] WeightInit = '0,
    parameter logic [InVecLength*(IntBits+FracBits)-1:0] BiasInit   = '0
) (
    input  logic                                     clk_in,
    input  logic                                     rst_in,
    input  logic                                     relu_en,
    input  logic                                     in_valid,
    output logic                                     in_ready,
    input  logic [WorkingRegs*(IntBits+FracBits)-1:0] in_data,
    output logic                                     out_valid,
    input  logic                                     out_ready,
    output logic [WorkingRegs*(IntBits+FracBits)-1:0] out_data,
    output logic                                     out_last,
    output logic                                     out_sat,
    output logic                                     sat_sticky
);

    localparam int NB   = nbits(IntBits, FracBits);
    localparam int NC   = num_chunks(InVecLength, WorkingRegs);
    localparam int PtrW = ptr_width(NC);
    localparam int RowW = WorkingRegs * NB;

    logic             stall, en, accept;
    logic [PtrW-1:0]  ptr_q, ptr_d;
    logic             v0_q, v0_d, v1_q, v1_d, v2_q, v2_d;
    logic             last0_q, last0_d, last1_q, last1_d, last2_q, last2_d;
    logic             relu0_q, relu0_d;
    logic [RowW-1:0]  x0_q, x0_d;
    logic             sticky_q, sticky_d;
    logic [RowW-1:0]  w_row, b_row, y_row;
    logic [WorkingRegs-1:0] lane_sat;

    always_comb begin
        stall   = v2_q & ~out_ready;
        en      = ~stall;
        accept  = in_valid & en;
        ptr_d   = ptr_q;
        v0_d    = v0_q;
        v1_d    = v1_q;
        v2_d    = v2_q;
        last0_d = last0_q;
        last1_d = last1_q;
        last2_d = last2_q;
        relu0_d = relu0_q;
        x0_d    = x0_q;
        if (en) begin
            v0_d    = in_valid;
            x0_d    = in_data;
            relu0_d = relu_en;
            last0_d = (ptr_q == PtrW'(NC - 1));
            v1_d    = v0_q;
            last1_d = last0_q;
            v2_d    = v1_q;
            last2_d = last1_q;
            if (accept) begin
                ptr_d = (ptr_q == PtrW'(NC - 1)) ? '0 : ptr_q + PtrW'(1);
            end
        end
        sticky_d = sticky_q | (v2_q & out_ready & out_sat);
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            ptr_q    <= '0;
            v0_q     <= 1'b0;
            v1_q     <= 1'b0;
            v2_q     <= 1'b0;
            last0_q  <= 1'b0;
            last1_q  <= 1'b0;
            last2_q  <= 1'b0;
            relu0_q  <= 1'b0;
            x0_q     <= '0;
            sticky_q <= 1'b0;
        end else begin
            ptr_q    <= ptr_d;
            v0_q     <= v0_d;
            v1_q     <= v1_d;
            v2_q     <= v2_d;
            last0_q  <= last0_d;
            last1_q  <= last1_d;
            last2_q  <= last2_d;
            relu0_q  <= relu0_d;
            x0_q     <= x0_d;
            sticky_q <= sticky_d;
        end
    end

    // ROM rows are addressed by the chunk pointer in the accept cycle so they line up with S0.
    vwb_sp_ram #(
        .Width   (RowW),
        .Depth   (NC),
        .AddrW   (PtrW),
        .InitFile(WeightFile),
        .InitData(WeightInit)
    ) u_wrom (
        .clk_in(clk_in),
        .ena   (en),
        .wea   (1'b0),
        .addr  (ptr_q),
        .din   ('0),
        .dout  (w_row)
    );

    vwb_sp_ram #(
        .Width   (RowW),
        .Depth   (NC),
        .AddrW   (PtrW),
        .InitFile(BiasFile),
        .InitData(BiasInit)
    ) u_brom (
        .clk_in(clk_in),
        .ena   (en),
        .wea   (1'b0),
        .addr  (ptr_q),
        .din   ('0),
        .dout  (b_row)
    );

    for (genvar g = 0; g < WorkingRegs; g++) begin : g_lane
        vwb_lane #(
            .NBits   (NB),
            .FracBits(FracBits),
            .Saturate(Saturate)
        ) u_lane (
            .clk_in(clk_in),
            .rst_in(rst_in),
            .en    (en),
            .relu  (relu0_q),
            .x     (x0_q[g*NB +: NB]),
            .w     (w_row[g*NB +: NB]),
            .b     (b_row[g*NB +: NB]),
            .y     (y_row[g*NB +: NB]),
            .sat   (lane_sat[g])
        );
    end

    assign in_ready   = ~stall;
    assign out_valid  = v2_q;
    assign out_data   = y_row;
    assign out_last   = last2_q;
    assign out_sat    = |lane_sat;
    assign sat_sticky = sticky_q;

endmodule

// File: tb/tb_vwb_mac_stream.sv
// Scoreboard bench: saturating and wrapping instances share stimulus, checked against an arithmetic model.
module tb_vwb_mac_stream;

    localparam int NC = 4;
    localparam logic [255:0] WINIT =
        256'h2000_8001_7000_0400_FFFF_3000_0800_C000_0001_7FFF_8000_1000_0800_F000_7000_2000;
    localparam logic [255:0] BINIT =
        256'hF000_0001_4000_8000_0000_1234_0000_0000_FF00_0100_8000_7FFF_0000_0000_0000_0400;

    logic        clk = 1'b0;
    logic        rst, relu_en, in_valid, out_ready;
    logic [63:0] in_data;
    logic        in_ready, out_valid, out_last, out_sat, sat_sticky;
    logic [63:0] out_data;
    logic        in_ready_w, out_valid_w, out_last_w, out_sat_w, sat_sticky_w;
    logic [63:0] out_data_w;

    always #5 clk = ~clk;

    vwb_mac_stream #(
        .InVecLength(16), .WorkingRegs(4), .IntBits(4), .FracBits(12), .Saturate(1),
        .WeightFile(""), .BiasFile(""), .WeightInit(WINIT), .BiasInit(BINIT)
    ) dut (
        .clk_in(clk), .rst_in(rst), .relu_en(relu_en), .in_valid(in_valid),
        .in_ready(in_ready), .in_data(in_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .out_sat(out_sat), .sat_sticky(sat_sticky)
    );

    vwb_mac_stream #(
        .InVecLength(16), .WorkingRegs(4), .IntBits(4), .FracBits(12), .Saturate(0),
        .WeightFile(""), .BiasFile(""), .WeightInit(WINIT), .BiasInit(BINIT)
    ) dut_w (
        .clk_in(clk), .rst_in(rst), .relu_en(relu_en), .in_valid(in_valid),
        .in_ready(in_ready_w), .in_data(in_data), .out_valid(out_valid_w),
        .out_ready(out_ready), .out_data(out_data_w), .out_last(out_last_w),
        .out_sat(out_sat_w), .sat_sticky(sat_sticky_w)
    );

    typedef struct {
        logic [63:0] sat_data;
        logic [63:0] wrap_data;
        logic        last;
        logic        sat;
        int          acc;
        bit          chk_lat;
    } exp_t;

    exp_t         sb[$];
    int           errors = 0;
    int           checks = 0;
    int           cyc = 0;
    int           ptr_m = 0;
    bit           sticky_m = 1'b0;
    bit           lat_mode = 1'b0;
    logic [255:0] wtab = WINIT;
    logic [255:0] btab = BINIT;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain integer arithmetic on Q4.12 values.
    function automatic exp_t model(input logic [63:0] x, input bit relu, input int row);
        exp_t        e;
        longint      wv, bv, xv, p, r, s, ys;
        logic [15:0] yw;
        logic [63:0] ysl;
        e.sat = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wv = $signed(wtab[row*64 + i*16 +: 16]);
            bv = $signed(btab[row*64 + i*16 +: 16]);
            xv = $signed(x[i*16 +: 16]);
            p  = wv * xv;
            r  = (p + 2048) >>> 12;
            s  = r + bv;
            ys = s;
            if (s > 32767) begin
                ys = 32767;
                e.sat = 1'b1;
            end else if (s < -32768) begin
                ys = -32768;
                e.sat = 1'b1;
            end
            if (relu && ys < 0) ys = 0;
            ysl = ys;
            yw  = s[15:0];
            if (relu && yw[15]) yw = 16'h0000;
            e.sat_data[i*16 +: 16]  = ysl[15:0];
            e.wrap_data[i*16 +: 16] = yw;
        end
        e.last    = (row == NC - 1);
        e.acc     = 0;
        e.chk_lat = 1'b0;
        return e;
    endfunction

    task automatic step(input bit v, input logic [63:0] x, input bit relu, input bit rdy,
                        output bit acc);
        exp_t e;
        @(posedge clk);
        #1;
        in_valid  = v;
        in_data   = x;
        relu_en   = relu;
        out_ready = rdy;
        @(negedge clk);
        acc = v && in_ready;
        if (acc) begin
            e         = model(x, relu, ptr_m);
            e.acc     = cyc;
            e.chk_lat = lat_mode;
            sb.push_back(e);
            ptr_m = (ptr_m + 1) % NC;
        end
    endtask

    task automatic send_chunk(input logic [63:0] x, input bit relu, input int vpct, input int rpct);
        bit acc;
        int guard;
        acc   = 1'b0;
        guard = 0;
        while (!acc && guard < 100) begin
            step($urandom_range(99) < vpct, x, relu, $urandom_range(99) < rpct, acc);
            guard++;
        end
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: chunk %h not accepted within %0d cycles", x, guard);
        end
    endtask

    function automatic logic [63:0] rand64();
        return {$urandom, $urandom};
    endfunction

    // Monitor: pops on each output handshake, and checks hold stability under stall.
    exp_t        me;
    bit          hold_pending = 1'b0;
    logic [63:0] held_data;
    logic [1:0]  held_ls;

    always @(negedge clk) begin
        if (rst) begin
            hold_pending = 1'b0;
        end else begin
            if (hold_pending) begin
                check("hold_valid", {63'd0, out_valid}, 64'd1);
                check("hold_data", out_data, held_data);
                check("hold_last_sat", {62'd0, out_last, out_sat}, {62'd0, held_ls});
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got %h with no chunk outstanding", out_data);
                end else begin
                    me = sb.pop_front();
                    check("data", out_data, me.sat_data);
                    check("last", {63'd0, out_last}, {63'd0, me.last});
                    check("sat", {63'd0, out_sat}, {63'd0, me.sat});
                    check("sticky", {63'd0, sat_sticky}, {63'd0, sticky_m});
                    check("wrap_valid", {63'd0, out_valid_w}, 64'd1);
                    check("wrap_data", out_data_w, me.wrap_data);
                    check("wrap_last", {63'd0, out_last_w}, {63'd0, me.last});
                    check("wrap_sat", {63'd0, out_sat_w}, 64'd0);
                    if (me.chk_lat) check("latency", 64'(cyc - me.acc), 64'd3);
                    sticky_m = sticky_m | me.sat;
                end
            end
            hold_pending = out_valid && !out_ready;
            held_data    = out_data;
            held_ls      = {out_last, out_sat};
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        rst       = 1'b1;
        in_valid  = 1'b0;
        relu_en   = 1'b0;
        out_ready = 1'b1;
        in_data   = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_out_data", out_data, 64'd0);
        check("rst_out_last", {63'd0, out_last}, 64'd0);
        check("rst_out_sat", {63'd0, out_sat}, 64'd0);
        check("rst_sticky", {63'd0, sat_sticky}, 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Directed vectors back to back with latency tracking.
        lat_mode = 1'b1;
        send_chunk(64'h0001_0800_7000_1800, 1'b0, 100, 100);
        for (int i = 0; i < 3; i++) send_chunk(rand64(), 1'b0, 100, 100);
        send_chunk(64'hFFFF_0800_7000_1800, 1'b1, 100, 100);
        for (int i = 0; i < 3; i++) send_chunk(rand64(), 1'($urandom_range(1)), 100, 100);
        for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b0, 1'b1, acc);
        lat_mode = 1'b0;

        // Five-cycle output stall mid-stream.
        for (int i = 0; i < 4; i++) send_chunk(rand64(), 1'b0, 100, 100);
        begin
            logic [63:0] xh;
            xh = rand64();
            for (int i = 0; i < 5; i++) begin
                step(1'b1, xh, 1'b0, 1'b0, acc);
                check("stall_in_ready", {63'd0, in_ready}, 64'd0);
                check("stall_in_ready_w", {63'd0, in_ready_w}, 64'd0);
            end
            send_chunk(xh, 1'b0, 100, 100);
        end
        for (int i = 0; i < 3; i++) send_chunk(rand64(), 1'b1, 100, 100);
        for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b0, 1'b1, acc);

        // Reset partway through a vector.
        send_chunk(rand64(), 1'b0, 100, 100);
        send_chunk(rand64(), 1'b0, 100, 100);
        @(posedge clk);
        #1;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        sb.delete();
        ptr_m    = 0;
        sticky_m = 1'b0;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("post_rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("post_rst_sticky", {63'd0, sat_sticky}, 64'd0);
        check("post_rst_in_ready", {63'd0, in_ready}, 64'd1);
        send_chunk(64'h0001_0800_7000_1800, 1'b0, 100, 100);
        for (int i = 0; i < 3; i++) send_chunk(rand64(), 1'b0, 100, 100);

        // Random traffic with random backpressure and ReLU.
        for (int i = 0; i < 60; i++) begin
            send_chunk(rand64(), 1'($urandom_range(1)), 70, 70);
        end

        begin
            int guard;
            guard = 0;
            while (sb.size() != 0 && guard < 50) begin
                step(1'b0, '0, 1'b0, 1'b1, acc);
                guard++;
            end
        end
        check("drained", 64'(sb.size()), 64'd0);
        check("final_wrap_sticky", {63'd0, sat_sticky_w}, 64'd0);
        check("final_sticky", {63'd0, sat_sticky}, {63'd0, sticky_m});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
